// File: rtl/fb_swap_ctrl.sv
// ---------------------------------------------------------------------------
// fb_swap_ctrl
//   Ping-pong framebuffer controller. VGA scanout always reads the front bank
//   and the renderer always writes the back bank. The two banks swap only on a
//   vsync rising edge, and only after the renderer has reported a finished
//   frame. An optional cap (MIN_VSYNCS) limits how often swaps may happen.
//
// Ports
//   vga_clk_in        pixel clock (sole clock)
//   rst_in            synchronous active-high reset
//   vsync_in          raw vsync, active high
//   render_done_in    1-cycle pulse: back buffer fully written
//   render_start_out  1-cycle pulse: renderer may start on the back buffer
//   rd_addr_in/out    scanout address in, {front_sel, addr} to BRAM read port
//   wr_addr_in/out    renderer address in, {~front_sel, addr} to BRAM write port
//   wr_en_in/out      renderer write strobe in, gated strobe out
//   front_sel_out     bank on screen (0=A, 1=B)
//   frame_count_out   swaps since reset (wraps)
//   stall_count_out   vsync edges seen while the renderer was busy (saturates)
//   err_out           sticky protocol error
//   dbg_state_out     current FSM state (IDLE=0, RENDER=1, WAIT_SYNC=2, SWAP=3)
//
// Handshake: render_start_out pulses for exactly one cycle on every entry to
// RENDER; the renderer answers with a one-cycle render_done_in pulse while the
// controller is in RENDER. Writes and done pulses outside RENDER are dropped
// and flagged on err_out.
// ---------------------------------------------------------------------------
module fb_swap_ctrl #(
  parameter int ADDR_BITS  = 16,
  parameter int MIN_VSYNCS = 1,
  parameter int CNT_BITS   = 16
) (
  input  logic                 vga_clk_in,
  input  logic                 rst_in,
  input  logic                 vsync_in,
  input  logic                 render_done_in,
  output logic                 render_start_out,
  input  logic [ADDR_BITS-1:0] rd_addr_in,
  output logic [ADDR_BITS:0]   rd_addr_out,
  input  logic [ADDR_BITS-1:0] wr_addr_in,
  input  logic                 wr_en_in,
  output logic [ADDR_BITS:0]   wr_addr_out,
  output logic                 wr_en_out,
  output logic                 front_sel_out,
  output logic [CNT_BITS-1:0]  frame_count_out,
  output logic [CNT_BITS-1:0]  stall_count_out,
  output logic                 err_out,
  output logic [1:0]           dbg_state_out
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RENDER    = 2'd1,
    WAIT_SYNC = 2'd2,
    SWAP      = 2'd3
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0] MIN_V   = CNT_BITS'(MIN_VSYNCS);

  state_t              r_state;
  logic                r_vsync_q;
  logic                r_front_sel;
  logic                r_render_start;
  logic [CNT_BITS-1:0] r_vs_cnt;
  logic [CNT_BITS-1:0] r_frame_cnt;
  logic [CNT_BITS-1:0] r_stall_cnt;
  logic                r_err;

  logic w_vs_rise;
  logic w_in_render;
  logic w_cap_ok;
  logic w_proto_err;

  assign w_vs_rise   = vsync_in & ~r_vsync_q;
  assign w_in_render = (r_state == RENDER);
  // One extra bit so vs_cnt+1 cannot overflow in the comparison.
  assign w_cap_ok    = ({1'b0, r_vs_cnt} + {1'b0, CNT_ONE}) >= {1'b0, MIN_V};
  assign w_proto_err = ~w_in_render & (wr_en_in | render_done_in);

  // Steering is purely combinational so the scanout pipeline sees no latency.
  assign rd_addr_out      = {r_front_sel, rd_addr_in};
  assign wr_addr_out      = {~r_front_sel, wr_addr_in};
  assign wr_en_out        = wr_en_in & w_in_render;
  assign front_sel_out    = r_front_sel;
  assign render_start_out = r_render_start;
  assign frame_count_out  = r_frame_cnt;
  assign stall_count_out  = r_stall_cnt;
  assign err_out          = r_err;
  assign dbg_state_out    = r_state;

  always_ff @(posedge vga_clk_in) begin
    if (rst_in) begin
      r_state        <= IDLE;
      r_vsync_q      <= 1'b0;
      r_front_sel    <= 1'b0;
      r_render_start <= 1'b0;
      r_vs_cnt       <= '0;
      r_frame_cnt    <= '0;
      r_stall_cnt    <= '0;
      r_err          <= 1'b0;
    end else begin
      r_vsync_q      <= vsync_in;
      r_render_start <= 1'b0;

      if (w_proto_err) begin
        r_err <= 1'b1;
      end

      // vsync edges since the last swap; counts in every state but SWAP.
      if (r_state == SWAP) begin
        r_vs_cnt <= '0;
      end else if (w_vs_rise && (r_vs_cnt < MIN_V)) begin
        r_vs_cnt <= r_vs_cnt + CNT_ONE;
      end

      case (r_state)
        IDLE: begin
          r_state        <= RENDER;
          r_render_start <= 1'b1;
        end
        RENDER: begin
          // A done pulse coinciding with vsync moves on without a stall;
          // that edge only advances vs_cnt and cannot swap.
          if (render_done_in) begin
            r_state <= WAIT_SYNC;
          end else if (w_vs_rise && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
          end
        end
        WAIT_SYNC: begin
          // Swap effects are registered on entry so that the outputs already
          // show the new bank during the SWAP cycle, one cycle after the edge.
          if (w_vs_rise && w_cap_ok) begin
            r_state     <= SWAP;
            r_front_sel <= ~r_front_sel;
            r_frame_cnt <= r_frame_cnt + CNT_ONE;
            r_vs_cnt    <= '0;
          end
        end
        SWAP: begin
          r_state        <= RENDER;
          r_render_start <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
